// File: rtl/sprite_draw_ctrl_if.sv
// Plot-side bundle between the drawing sequencer and its host / VGA path.
// Ports:
//   go, screen, clear, xInitSel, yInitSel, memorySel : host -> sequencer request
//   memorySelOut, romAddr, x, y, plot, black, busy, done : sequencer -> ROM / VGA / host
// Modports: slave = sequencer side, master = host side.
interface sprite_draw_ctrl_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              go;
  logic              screen;
  logic              clear;
  logic [3:0]        xInitSel;
  logic [1:0]        yInitSel;
  logic [4:0]        memorySel;
  logic [4:0]        memorySelOut;
  logic [ADDR_W-1:0] romAddr;
  logic [7:0]        x;
  logic [6:0]        y;
  logic              plot;
  logic              black;
  logic              busy;
  logic              done;

  modport slave (
    input  go, screen, clear, xInitSel, yInitSel, memorySel,
    output memorySelOut, romAddr, x, y, plot, black, busy, done
  );

  modport master (
    output go, screen, clear, xInitSel, yInitSel, memorySel,
    input  memorySelOut, romAddr, x, y, plot, black, busy, done
  );
endinterface

// File: rtl/sprite_draw_ctrl.sv
// Drawing sequencer: sweeps a sprite- or screen-sized rectangle in raster
// order, issues one linear ROM address per cycle and delivers x/y/plot
// ROM_LAT cycles later so they meet the synchronous ROM colour.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : sprite_draw_ctrl_if.slave (request in, ROM address / plot out)
module sprite_draw_ctrl #(
  parameter int unsigned SPRITE_W = 40,
  parameter int unsigned SPRITE_H = 40,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned ADDR_W   = 15
) (
  input  logic               clk,
  input  logic               reset,
  sprite_draw_ctrl_if.slave  bus
);
  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 7;
  localparam int unsigned FCNT_W = 2;

  typedef enum logic [2:0] {IDLE, LOAD, DRAW, FLUSH, DONE} state_t;

  state_t              state_q, state_d;
  logic                issue, last_pix, clear_now;
  logic                full_q, clear_q;
  logic [3:0]          xsel_q;
  logic [1:0]          ysel_q;
  logic [4:0]          msel_q;
  logic [X_W-1:0]      xinit_q, lastx_q, dx_q;
  logic [Y_W-1:0]      yinit_q, lasty_q, dy_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [FCNT_W-1:0]   fcnt_q;
  logic                busy_q, done_q, black_q;
  logic                pv_q [ROM_LAT];
  logic [X_W-1:0]      px_q [ROM_LAT];
  logic [Y_W-1:0]      py_q [ROM_LAT];

  // Battle-position column table.
  function automatic logic [X_W-1:0] xinit_of(input logic [3:0] sel);
    case (sel)
      4'd1:    xinit_of = 8'd36;
      4'd2:    xinit_of = 8'd30;
      4'd3:    xinit_of = 8'd24;
      4'd4:    xinit_of = 8'd18;
      4'd5:    xinit_of = 8'd12;
      4'd6:    xinit_of = 8'd6;
      4'd8:    xinit_of = 8'd90;
      4'd9:    xinit_of = 8'd96;
      4'd10:   xinit_of = 8'd102;
      4'd11:   xinit_of = 8'd108;
      4'd12:   xinit_of = 8'd114;
      4'd13:   xinit_of = 8'd120;
      default: xinit_of = 8'd0;
    endcase
  endfunction

  // Next-state decode.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    last_pix  = (dx_q == lastx_q) && (dy_q == lasty_q);
    clear_now = (state_q == IDLE) ? bus.clear : clear_q;
    case (state_q)
      IDLE:  if (bus.go) state_d = LOAD;
      LOAD:  state_d = DRAW;
      DRAW: begin
        issue = 1'b1;
        if (last_pix) state_d = FLUSH;
      end
      FLUSH: if (fcnt_q == FCNT_W'(ROM_LAT - 1)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and alignment pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      full_q  <= 1'b0;
      clear_q <= 1'b0;
      xsel_q  <= '0;
      ysel_q  <= '0;
      msel_q  <= '0;
      xinit_q <= '0;
      yinit_q <= '0;
      lastx_q <= '0;
      lasty_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      addr_q  <= '0;
      fcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      black_q <= 1'b0;
      for (int i = 0; i < ROM_LAT; i++) begin
        pv_q[i] <= 1'b0;
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      black_q <= (state_d != IDLE) && clear_now;

      if (state_q == IDLE && bus.go) begin
        full_q  <= bus.screen | bus.clear;
        clear_q <= bus.clear;
        xsel_q  <= bus.xInitSel;
        ysel_q  <= bus.yInitSel;
        msel_q  <= bus.memorySel;
      end

      case (state_q)
        LOAD: begin
          xinit_q <= full_q ? '0 : xinit_of(xsel_q);
          yinit_q <= (!full_q && ysel_q == 2'b01) ? 7'd30 : '0;
          lastx_q <= full_q ? X_W'(SCREEN_W - 1) : X_W'(SPRITE_W - 1);
          lasty_q <= full_q ? Y_W'(SCREEN_H - 1) : Y_W'(SPRITE_H - 1);
          dx_q    <= '0;
          dy_q    <= '0;
          addr_q  <= '0;
          fcnt_q  <= '0;
        end
        DRAW: begin
          // Raster order makes dy*W+dx a plain running count; hold on the last pixel.
          if (!last_pix) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (dx_q == lastx_q) begin
              dx_q <= '0;
              dy_q <= dy_q + Y_W'(1);
            end else begin
              dx_q <= dx_q + X_W'(1);
            end
          end
        end
        FLUSH: fcnt_q <= fcnt_q + FCNT_W'(1);
        default: ;
      endcase

      // Coordinates only move with a valid token so x/y hold between plots.
      pv_q[0] <= issue;
      if (issue) begin
        px_q[0] <= xinit_q + dx_q;
        py_q[0] <= yinit_q + dy_q;
      end
      for (int i = 1; i < ROM_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        if (pv_q[i-1]) begin
          px_q[i] <= px_q[i-1];
          py_q[i] <= py_q[i-1];
        end
      end
    end
  end

  assign bus.memorySelOut = msel_q;
  assign bus.romAddr      = addr_q;
  assign bus.x            = px_q[ROM_LAT-1];
  assign bus.y            = py_q[ROM_LAT-1];
  assign bus.plot         = pv_q[ROM_LAT-1];
  assign bus.black        = black_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_sprite_draw_ctrl.sv
// Scoreboard bench for sprite_draw_ctrl: two instances (ROM_LAT=1 and 3)
// receive identical requests; expected plots are queued per instance and a
// negedge monitor pops and compares on every plot.
module tb_sprite_draw_ctrl;
  localparam int unsigned ADDR_W = 15;

  typedef struct packed {
    logic [4:0]  msel;
    logic        black;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] addr;
  } pix_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sprite_draw_ctrl_if #(.ADDR_W(ADDR_W)) bus1 ();
  sprite_draw_ctrl_if #(.ADDR_W(ADDR_W)) bus3 ();

  sprite_draw_ctrl #(.ROM_LAT(1), .ADDR_W(ADDR_W)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  sprite_draw_ctrl #(.ROM_LAT(3), .ADDR_W(ADDR_W)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int plots [2] = '{0, 0};
  int dones [2] = '{0, 0};
  int done_cyc [2] = '{0, 0};
  logic [14:0] hist [2][4];
  pix_t q1 [$];
  pix_t q3 [$];
  int xtab [16] = '{0, 36, 30, 24, 18, 12, 6, 0, 90, 96, 102, 108, 114, 120, 0, 0};

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  // Pop-and-compare for one instance; hist[d][lat-1] is romAddr from the issue cycle.
  task automatic mon_step(input int d, input int lat, input logic p, input logic [7:0] xa,
                          input logic [6:0] ya, input logic [14:0] addr, input logic blk,
                          input logic [4:0] ms, input logic dn);
    pix_t act;
    pix_t exp;
    int   qs;
    if (p === 1'b1) begin
      plots[d]++;
      n_cmp++;
      act.msel  = ms;
      act.black = blk;
      act.x     = xa;
      act.y     = ya;
      act.addr  = hist[d][lat-1];
      qs = (d == 0) ? q1.size() : q3.size();
      if (qs == 0) begin
        n_err++;
        $display("FAIL plot_unexpected lat%0d: got plot x=%0d y=%0d, required no plot", lat, xa, ya);
      end else begin
        if (d == 0) exp = q1.pop_front();
        else        exp = q3.pop_front();
        if (act !== exp)
          begin
            n_err++;
            $display("FAIL plot lat%0d #%0d: got msel=%h blk=%b x=%0d y=%0d addr=%0d, required msel=%h blk=%b x=%0d y=%0d addr=%0d",
                     lat, plots[d], act.msel, act.black, act.x, act.y, act.addr,
                     exp.msel, exp.black, exp.x, exp.y, exp.addr);
          end
      end
    end
    if (dn === 1'b1) begin
      dones[d]++;
      done_cyc[d] = cyc;
    end
    for (int i = 3; i > 0; i--) hist[d][i] = hist[d][i-1];
    hist[d][0] = addr;
  endtask

  always @(negedge clk) begin
    mon_step(0, 1, bus1.plot, bus1.x, bus1.y, bus1.romAddr, bus1.black, bus1.memorySelOut, bus1.done);
    mon_step(1, 3, bus3.plot, bus3.x, bus3.y, bus3.romAddr, bus3.black, bus3.memorySelOut, bus3.done);
  end

  task automatic set_in(input logic g, input logic scr, input logic clr,
                        input logic [3:0] xs, input logic [1:0] ys, input logic [4:0] ms);
    bus1.go = g; bus1.screen = scr; bus1.clear = clr;
    bus1.xInitSel = xs; bus1.yInitSel = ys; bus1.memorySel = ms;
    bus3.go = g; bus3.screen = scr; bus3.clear = clr;
    bus3.xInitSel = xs; bus3.yInitSel = ys; bus3.memorySel = ms;
  endtask

  // Expected raster for one sweep, pushed to both scoreboards.
  task automatic push_sweep(input logic [3:0] xs, input logic [1:0] ys, input logic scr,
                            input logic clr, input logic [4:0] ms, output int npix);
    int x0, y0, w, h;
    pix_t e;
    x0 = xtab[xs];
    y0 = (ys == 2'b01) ? 30 : 0;
    w = 40; h = 40;
    if (scr || clr) begin
      x0 = 0; y0 = 0; w = 160; h = 120;
    end
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++) begin
        e.msel = ms; e.black = clr;
        e.x = 8'(x0 + i); e.y = 7'(y0 + j); e.addr = 15'(j * w + i);
        q1.push_back(e);
        q3.push_back(e);
      end
    npix = w * h;
  endtask

  task automatic run_sweep(input string name, input logic [3:0] xs, input logic [1:0] ys,
                           input logic scr, input logic clr, input logic [4:0] ms, input bit mid_go);
    int npix, c0, budget;
    int p0 [2];
    int d0 [2];
    push_sweep(xs, ys, scr, clr, ms, npix);
    p0 = plots; d0 = dones;
    @(negedge clk);
    set_in(1'b1, scr, clr, xs, ys, ms);
    c0 = cyc;
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 5'd0);
    if (mid_go) begin
      repeat (300) @(negedge clk);
      set_in(1'b1, ~scr, ~clr, ~xs, ~ys, ~ms);
      @(negedge clk);
      set_in(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 5'd0);
    end
    budget = 0;
    while ((dones[0] == d0[0] || dones[1] == d0[1]) && budget < 25000) begin
      @(negedge clk);
      budget++;
    end
    check({name, "_timeout"}, int'(budget < 25000), 1);
    repeat (6) @(negedge clk);
    check({name, "_done_cnt_lat1"}, dones[0] - d0[0], 1);
    check({name, "_done_cnt_lat3"}, dones[1] - d0[1], 1);
    check({name, "_plots_lat1"}, plots[0] - p0[0], npix);
    check({name, "_plots_lat3"}, plots[1] - p0[1], npix);
    check({name, "_done_edge_lat1"}, done_cyc[0] - c0, npix + 2 + 1);
    check({name, "_done_edge_lat3"}, done_cyc[1] - c0, npix + 2 + 3);
    check({name, "_busy_after"}, int'({bus1.busy, bus3.busy}), 0);
    check({name, "_queue_left"}, q1.size() + q3.size(), 0);
  endtask

  initial begin
    int npix, p0, d0, budget;
    // Reset with go asserted: everything must read back zero.
    reset = 1'b1;
    set_in(1'b1, 1'b1, 1'b1, 4'b1000, 2'b01, 5'b11111);
    repeat (2) @(negedge clk);
    check("reset_out_lat1", int'({bus1.plot, bus1.busy, bus1.done, bus1.x, bus1.y, bus1.romAddr,
                                  bus1.black, bus1.memorySelOut}), 0);
    check("reset_out_lat3", int'({bus3.plot, bus3.busy, bus3.done, bus3.x, bus3.y, bus3.romAddr,
                                  bus3.black, bus3.memorySelOut}), 0);
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 5'd0);
    repeat (3) @(negedge clk);
    check("reset_go_ignored", int'({bus1.busy, bus3.busy}), 0);

    run_sweep("sprite_right", 4'b1000, 2'b01, 1'b0, 1'b0, 5'b01010, 1'b0);
    run_sweep("screen", 4'b0101, 2'b01, 1'b1, 1'b0, 5'b00011, 1'b1);
    run_sweep("clear", 4'b0011, 2'b01, 1'b0, 1'b1, 5'b00100, 1'b0);
    check("black_after_clear", int'({bus1.black, bus3.black}), 0);
    run_sweep("invalid_sel", 4'b1111, 2'b11, 1'b0, 1'b0, 5'b10001, 1'b0);

    // Abort mid-sweep with reset.
    push_sweep(4'b0001, 2'b00, 1'b0, 1'b0, 5'b00111, npix);
    p0 = plots[0];
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 4'b0001, 2'b00, 5'b00111);
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 5'd0);
    budget = 0;
    while (plots[0] - p0 < 500 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    check("abort_reach_500", int'(budget < 3000), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q1.delete();
    q3.delete();
    p0 = plots[0] + plots[1];
    d0 = dones[0] + dones[1];
    repeat (60) @(negedge clk);
    check("abort_no_plot", plots[0] + plots[1] - p0, 0);
    check("abort_no_done", dones[0] + dones[1] - d0, 0);
    check("abort_busy", int'({bus1.busy, bus3.busy}), 0);

    run_sweep("restart", 4'b1101, 2'b01, 1'b0, 1'b0, 5'b01010, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
